// File: rtl/mem_dump_tx_pkg.sv
// Shared definitions for the memory-dump transmitter.
// Holds the dump FSM state encoding, UART 8N1 frame constants and the
// word/byte geometry used by mem_dump_tx and uart_byte_tx.
package mem_dump_tx_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    // UART 8N1 framing
    localparam int unsigned FRAME_BITS = 10;
    localparam logic        START_LVL  = 1'b0;
    localparam logic        STOP_LVL   = 1'b1;
    localparam logic        IDLE_LVL   = 1'b1;

    // One serial frame, transmitted LSB (start bit) first
    typedef struct packed {
        logic              stop;
        logic [BYTE_W-1:0] data;
        logic              start;
    } uart_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/mem_dump_if.sv
// Request / memory-read / serial bundle of the memory-dump transmitter.
//   start, base_addr, word_count : dump request from the host side
//   busy, done                   : dump status
//   mem_oe, mem_addr, mem_rdata  : synchronous 1-cycle-latency read port
//   txd                          : UART serial line
// slave = the transmitter, master = the surrounding system.
interface mem_dump_if
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              mem_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              txd;

    modport master (
        output start, base_addr, word_count, mem_rdata,
        input  busy, done, mem_oe, mem_addr, txd
    );

    modport slave (
        input  start, base_addr, word_count, mem_rdata,
        output busy, done, mem_oe, mem_addr, txd
    );
endinterface

// File: rtl/mem_dump_tx_uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serialiser.
//   clk, rst_async : clock, async active-high reset
//   tx_byte, load  : byte to send and its load strobe
//   txd            : registered serial output, idles high
//   ready_c        : high in the last cycle of the stop bit, so a load in that
//                    cycle starts the next frame with no idle gap
module uart_byte_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned SERIAL_WCNT = 100
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic [BYTE_W-1:0] tx_byte,
    input  logic              load,
    output logic              txd,
    output logic              ready_c
);
    localparam int unsigned CNT_W = (SERIAL_WCNT > 1) ? $clog2(SERIAL_WCNT) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic [CNT_W-1:0]  cyc_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BYTE_W:0]   shreg;     // remaining data bits + stop bit
    logic              active;
    logic              last_cyc;
    logic              last_bit;
    uart_frame_t       frame;

    assign frame    = '{stop: STOP_LVL, data: tx_byte, start: START_LVL};
    assign last_cyc = (cyc_cnt == CNT_W'(SERIAL_WCNT - 1));
    assign last_bit = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign ready_c  = active && last_cyc && last_bit;

    // Bit-period counter and frame shifter; start bit goes out on the load edge
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            txd     <= IDLE_LVL;
            shreg   <= '1;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            active  <= 1'b0;
        end else if (load) begin
            txd     <= frame.start;
            shreg   <= {frame.stop, frame.data};
            bit_cnt <= '0;
            cyc_cnt <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (last_cyc) begin
                cyc_cnt <= '0;
                if (last_bit) begin
                    active <= 1'b0;
                    txd    <= IDLE_LVL;
                end else begin
                    txd     <= shreg[0];
                    shreg   <= {IDLE_LVL, shreg[BYTE_W:1]};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end else begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: reads word_count words from base_addr over a 1-cycle-latency
// read port and sends each as four 8N1 bytes, LSB first, on txd.
//   clk, rst_async : clock, async active-high reset
//   bus (slave)    : start/base_addr/word_count request, busy/done status,
//                    mem_oe/mem_addr/mem_rdata read port, txd serial line
// Build option: MEM_DUMP_CKSUM_EN appends a 32-bit modulo-2^32 sum of the
// dumped words as four extra bytes after two idle cycles.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned SERIAL_WCNT = 100,
    parameter int unsigned ADDR_W      = 14
) (
    input  logic        clk,
    input  logic        rst_async,
    mem_dump_if.slave   bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [WORD_W-1:0] word_q, word_d;     // bytes still to send, next in [7:0]
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tx_load_c;
    logic [BYTE_W-1:0] tx_byte_c;
    logic              tx_ready_c;
    logic              byte_last_c;
`ifdef MEM_DUMP_CKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
    logic [1:0]        cph_q, cph_d;       // 0,1: idle gap, 2: sending sum
`endif

    assign byte_last_c = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    uart_byte_tx #(
        .SERIAL_WCNT (SERIAL_WCNT)
    ) u_uart (
        .clk       (clk),
        .rst_async (rst_async),
        .tx_byte   (tx_byte_c),
        .load      (tx_load_c),
        .txd       (bus.txd),
        .ready_c   (tx_ready_c)
    );

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        word_d    = word_q;
        idx_d     = idx_q;
        tx_load_c = 1'b0;
        tx_byte_c = word_q[BYTE_W-1:0];
`ifdef MEM_DUMP_CKSUM_EN
        sum_d     = sum_q;
        cph_d     = cph_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base_addr;
                    remain_d = bus.word_count;
`ifdef MEM_DUMP_CKSUM_EN
                    sum_d    = '0;
`endif
                    state_d  = (bus.word_count == '0) ? ST_FIN : ST_READ;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                // read data arrives now; byte 0 is loaded straight from it
                tx_load_c = 1'b1;
                tx_byte_c = bus.mem_rdata[BYTE_W-1:0];
                word_d    = {BYTE_W'(0), bus.mem_rdata[WORD_W-1:BYTE_W]};
                idx_d     = '0;
`ifdef MEM_DUMP_CKSUM_EN
                sum_d     = sum_q + bus.mem_rdata;
`endif
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready_c) begin
                    if (byte_last_c) begin
                        remain_d = remain_q - CNT_W'(1);
                        addr_d   = addr_q + ADDR_W'(1);
                        if (remain_d != '0) begin
                            state_d = ST_READ;
                        end else begin
`ifdef MEM_DUMP_CKSUM_EN
                            state_d = ST_CSUM;
                            cph_d   = 2'd0;
`else
                            state_d = ST_FIN;
`endif
                        end
                    end else begin
                        tx_load_c = 1'b1;
                        word_d    = {BYTE_W'(0), word_q[WORD_W-1:BYTE_W]};
                        idx_d     = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef MEM_DUMP_CKSUM_EN
            ST_CSUM: begin
                case (cph_q)
                    2'd0: cph_d = 2'd1;
                    2'd1: begin
                        cph_d     = 2'd2;
                        tx_load_c = 1'b1;
                        tx_byte_c = sum_q[BYTE_W-1:0];
                        word_d    = {BYTE_W'(0), sum_q[WORD_W-1:BYTE_W]};
                        idx_d     = '0;
                    end
                    default: begin
                        if (tx_ready_c) begin
                            if (byte_last_c) begin
                                state_d = ST_FIN;
                            end else begin
                                tx_load_c = 1'b1;
                                word_d    = {BYTE_W'(0), word_q[WORD_W-1:BYTE_W]};
                                idx_d     = idx_q + IDX_W'(1);
                            end
                        end
                    end
                endcase
            end
`endif
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            bus.mem_oe   <= 1'b0;
            bus.mem_addr <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
`ifdef MEM_DUMP_CKSUM_EN
            sum_q        <= '0;
            cph_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            bus.mem_oe <= (state_d == ST_READ);
            if (state_d == ST_READ) begin
                bus.mem_addr <= addr_d;
            end
            bus.busy   <= (state_d inside {ST_READ, ST_WAIT, ST_SEND, ST_CSUM});
            bus.done   <= (state_d == ST_FIN);
`ifdef MEM_DUMP_CKSUM_EN
            sum_q      <= sum_d;
            cph_q      <= cph_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx with SERIAL_WCNT=4, ADDR_W=14.
// A negedge monitor logs read strobes, done pulses, busy cycles and decodes
// txd into bytes; each scenario compares those logs against hand-derived values.
module tb_mem_dump_tx;
    localparam int          W       = 4;
    localparam int unsigned ADDR_W  = 14;
    localparam int          WORD_CY = 2 + 40 * W;   // cycles per word
`ifdef MEM_DUMP_CKSUM_EN
    localparam int          CK_EX   = 2 + 40 * W;   // checksum trailer
`else
    localparam int          CK_EX   = 0;
`endif

    logic clk = 1'b0;
    logic rst_async = 1'b1;
    always #5 clk = ~clk;

    mem_dump_if #(.ADDR_W(ADDR_W)) bus();

    mem_dump_tx #(
        .SERIAL_WCNT (W),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .bus       (bus)
    );

    // synchronous memory, 1-cycle read latency
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (bus.mem_oe) bus.mem_rdata <= mem[bus.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor logs
    int oe_cyc[$], oe_addr[$], done_cyc[$], rx_bytes[$], frame_starts[$];
    int busy_cnt = 0, txd_low = 0, stop_err = 0;
    bit rx_active = 1'b0;
    int rx_t = 0, rx_b = 0;
    logic [7:0] rx_sh = '0;

    always @(negedge clk) begin
        if (bus.mem_oe) begin
            oe_cyc.push_back(cyc);
            oe_addr.push_back(int'(bus.mem_addr));
        end
        if (bus.done) done_cyc.push_back(cyc);
        if (bus.busy) busy_cnt++;
        if (!bus.txd) txd_low++;
        if (rst_async) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (!bus.txd) begin
                rx_active = 1'b1;
                rx_t = 0;
                frame_starts.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t % W == W / 2) begin
                rx_b = rx_t / W;
                if (rx_b >= 1 && rx_b <= 8) begin
                    rx_sh[rx_b-1] = bus.txd;
                end else if (rx_b == 9) begin
                    if (!bus.txd) stop_err++;
                    rx_bytes.push_back(int'(rx_sh));
                    rx_active = 1'b0;
                end
            end
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic chk_bytes(input string tag, input int exp[$]);
        chk({tag, "_nbytes"}, rx_bytes.size(), exp.size());
        foreach (exp[i]) chk($sformatf("%s_b%0d", tag, i), qget(rx_bytes, i), exp[i]);
        chk({tag, "_stop_err"}, stop_err, 0);
    endtask

    task automatic clear_mon();
        oe_cyc.delete(); oe_addr.delete(); done_cyc.delete();
        rx_bytes.delete(); frame_starts.delete();
        busy_cnt = 0; txd_low = 0; stop_err = 0;
    endtask

    task automatic begin_dump(input int base, input int count, output int t);
        @(negedge clk);
        bus.base_addr  = ADDR_W'(base);
        bus.word_count = (ADDR_W+1)'(count);
        bus.start      = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cyc.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done_cyc.size() != 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int exp[$];
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        mem[14'h0010] = 32'hA1B2C3D4;
        mem[14'h3FFF] = 32'h11223344;
        mem[14'h0000] = 32'h55667788;
        mem[14'h0020] = 32'h01020304;
        mem[14'h0021] = 32'h05060708;
        mem[14'h0022] = 32'h090A0B0C;
        mem[14'h0050] = 32'hDEADBEEF;
        mem[14'h0051] = 32'h12345678;
        mem[14'h0060] = 32'h0BADF00D;
        mem[14'h0070] = 32'hFFFFFFFF;
        mem[14'h0071] = 32'h00000002;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_txd", bus.txd, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_oe", bus.mem_oe, 0);
        chk("rst_addr", bus.mem_addr, 0);
        rst_async = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();

        // single word, byte order and latency
        begin_dump('h10, 1, t);
        wait_done("t1");
        chk("t1_done_cyc", qget(done_cyc, 0), t + 1 + WORD_CY + CK_EX);
        chk("t1_ndone", done_cyc.size(), 1);
        chk("t1_noe", oe_cyc.size(), 1);
        chk("t1_oe_cyc", qget(oe_cyc, 0), t + 1);
        chk("t1_oe_addr", qget(oe_addr, 0), 'h10);
        chk("t1_first_start", qget(frame_starts, 0), t + 3);
        chk("t1_busy_cycles", busy_cnt, WORD_CY + CK_EX);
        exp = '{'hD4, 'hC3, 'hB2, 'hA1};
`ifdef MEM_DUMP_CKSUM_EN
        exp = {exp, '{'hD4, 'hC3, 'hB2, 'hA1}};
`endif
        chk_bytes("t1", exp);
        clear_mon();

        // address wrap and inter-word gap
        begin_dump('h3FFF, 2, t);
        wait_done("t2");
        chk("t2_noe", oe_cyc.size(), 2);
        chk("t2_addr0", qget(oe_addr, 0), 'h3FFF);
        chk("t2_addr1", qget(oe_addr, 1), 'h0000);
        chk("t2_b2b", qget(frame_starts, 1) - qget(frame_starts, 0), 10 * W);
        chk("t2_word_gap", qget(frame_starts, 4) - qget(frame_starts, 3), 10 * W + 2);
        chk("t2_done_cyc", qget(done_cyc, 0), t + 1 + 2 * WORD_CY + CK_EX);
        exp = '{'h44, 'h33, 'h22, 'h11, 'h88, 'h77, 'h66, 'h55};
`ifdef MEM_DUMP_CKSUM_EN
        exp = {exp, '{'hCC, 'hAA, 'h88, 'h66}};
`endif
        chk_bytes("t2", exp);
        clear_mon();

        // zero-length dump
        begin_dump('h5, 0, t);
        wait_done("t3");
        chk("t3_done_cyc", qget(done_cyc, 0), t + 1);
        chk("t3_busy", busy_cnt, 0);
        chk("t3_txd_low", txd_low, 0);
        chk("t3_noe", oe_cyc.size(), 0);
        clear_mon();

        // start while busy is ignored
        begin_dump('h20, 3, t);
        wait_cyc(t + 100);
        bus.base_addr = ADDR_W'('h30);
        bus.word_count = (ADDR_W+1)'(1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t4");
        repeat (200) @(negedge clk);
        chk("t4_ndone", done_cyc.size(), 1);
        chk("t4_done_cyc", qget(done_cyc, 0), t + 1 + 3 * WORD_CY + CK_EX);
        chk("t4_noe", oe_cyc.size(), 3);
        chk("t4_addr0", qget(oe_addr, 0), 'h20);
        chk("t4_addr1", qget(oe_addr, 1), 'h21);
        chk("t4_addr2", qget(oe_addr, 2), 'h22);
        exp = '{'h04, 'h03, 'h02, 'h01, 'h08, 'h07, 'h06, 'h05, 'h0C, 'h0B, 'h0A, 'h09};
`ifdef MEM_DUMP_CKSUM_EN
        exp = {exp, '{'h18, 'h15, 'h12, 'h0F}};
`endif
        chk_bytes("t4", exp);
        clear_mon();

        // reset in the middle of byte 1's start bit
        begin_dump('h50, 2, t);
        wait_cyc(t + 44);
        chk("t5_pre_txd", bus.txd, 0);
        rst_async = 1'b1;
        #1;
        chk("t5_rst_txd", bus.txd, 1);
        chk("t5_rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_async = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_nbytes_trunc", rx_bytes.size(), 1);
        chk("t5_byte0", qget(rx_bytes, 0), 'hEF);
        chk("t5_ndone_trunc", done_cyc.size(), 0);
        clear_mon();
        begin_dump('h60, 1, t);
        wait_done("t5");
        chk("t5_noe", oe_cyc.size(), 1);
        chk("t5_addr", qget(oe_addr, 0), 'h60);
        chk("t5_done_cyc", qget(done_cyc, 0), t + 1 + WORD_CY + CK_EX);
        exp = '{'h0D, 'hF0, 'hAD, 'h0B};
`ifdef MEM_DUMP_CKSUM_EN
        exp = {exp, '{'h0D, 'hF0, 'hAD, 'h0B}};
`endif
        chk_bytes("t5", exp);
        clear_mon();

`ifdef MEM_DUMP_CKSUM_EN
        // checksum wraps modulo 2^32
        begin_dump('h70, 2, t);
        wait_done("t6");
        chk("t6_done_cyc", qget(done_cyc, 0), t + 1 + 2 * WORD_CY + CK_EX);
        chk("t6_csum_gap", qget(frame_starts, 8) - qget(frame_starts, 7), 10 * W + 2);
        exp = '{'hFF, 'hFF, 'hFF, 'hFF, 'h02, 'h00, 'h00, 'h00, 'h01, 'h00, 'h00, 'h00};
        chk_bytes("t6", exp);
        clear_mon();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
